// File: rtl/fetch_stage.sv
// Instruction fetch stage: owns the PC, issues single-outstanding imem requests and
// presents fetched words in an IF/ID register backed by a one-entry skid buffer.
module fetch_stage #(
  parameter int unsigned       ADDR_W   = 32,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic              clk,
  input  logic              rst,
  output logic              imem_req,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic              imem_ack,
  input  logic [31:0]       imem_rdata,
  input  logic              id_stall,
  input  logic              redirect_valid,
  input  logic [ADDR_W-1:0] redirect_pc,
  output logic              id_valid,
  output logic [31:0]       id_instr,
  output logic [ADDR_W-1:0] id_pc,
  output logic [5:0]        id_opcode,
  output logic [6:0]        id_functR,
  output logic [4:0]        id_rs,
  output logic [4:0]        id_rt,
  output logic [4:0]        id_rd,
  output logic [15:0]       id_imm
);

  localparam logic [ADDR_W-1:0] PC_STEP = ADDR_W'(4);

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    HOLD,
    DROP
  } state_e;

  state_e            state_q;
  logic              req_q;
  logic [ADDR_W-1:0] pc_q;
  logic [ADDR_W-1:0] addr_q;
  logic              id_valid_q;
  logic [31:0]       id_instr_q;
  logic [ADDR_W-1:0] id_pc_q;
  logic [31:0]       skid_instr_q;
  logic [ADDR_W-1:0] skid_pc_q;

  logic [ADDR_W-1:0] redirect_tgt;
  logic [ADDR_W-1:0] pc_inc;
  logic              out_free;

  assign redirect_tgt = {redirect_pc[ADDR_W-1:2], 2'b00};
  assign pc_inc       = pc_q + PC_STEP;
  assign out_free     = !id_valid_q || !id_stall;

  // The skid holds a word exactly while in HOLD, so leaving HOLD is what empties it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      req_q        <= 1'b0;
      pc_q         <= RESET_PC;
      addr_q       <= RESET_PC;
      id_valid_q   <= 1'b0;
      id_instr_q   <= '0;
      id_pc_q      <= '0;
      // NOTE: skid data is reset as well so no X can ever reach id_instr through it.
      skid_instr_q <= '0;
      skid_pc_q    <= '0;
    end else begin
      // NOTE: all state here uses <= so every branch sees the pre-edge register values.
      case (state_q)
        IDLE: begin
          state_q <= REQ;
          req_q   <= 1'b1;
          if (redirect_valid) begin
            pc_q   <= redirect_tgt;
            addr_q <= redirect_tgt;
          end else begin
            addr_q <= pc_q;
          end
        end

        REQ: begin
          if (redirect_valid) begin
            id_valid_q <= 1'b0;
            pc_q       <= redirect_tgt;
            if (imem_ack) begin
              addr_q <= redirect_tgt;
            end else begin
              // Request still in flight on the old address; its data must be thrown away.
              state_q <= DROP;
            end
          end else if (imem_ack) begin
            pc_q   <= pc_inc;
            addr_q <= pc_inc;
            if (out_free) begin
              id_valid_q <= 1'b1;
              id_instr_q <= imem_rdata;
              id_pc_q    <= pc_q;
            end else begin
              skid_instr_q <= imem_rdata;
              skid_pc_q    <= pc_q;
              state_q      <= HOLD;
              req_q        <= 1'b0;
            end
          end else if (!id_stall) begin
            id_valid_q <= 1'b0;
          end
        end

        HOLD: begin
          if (redirect_valid) begin
            id_valid_q <= 1'b0;
            pc_q       <= redirect_tgt;
            addr_q     <= redirect_tgt;
            state_q    <= REQ;
            req_q      <= 1'b1;
          end else if (!id_stall) begin
            id_valid_q <= 1'b1;
            id_instr_q <= skid_instr_q;
            id_pc_q    <= skid_pc_q;
            addr_q     <= pc_q;
            state_q    <= REQ;
            req_q      <= 1'b1;
          end
        end

        DROP: begin
          if (redirect_valid) begin
            pc_q <= redirect_tgt;
          end
          if (imem_ack) begin
            state_q <= REQ;
            addr_q  <= redirect_valid ? redirect_tgt : pc_q;
          end
        end

        default: begin
          state_q <= IDLE;
          req_q   <= 1'b0;
        end
      endcase
    end
  end

  assign imem_req  = req_q;
  assign imem_addr = addr_q;
  assign id_valid  = id_valid_q;
  assign id_instr  = id_instr_q;
  assign id_pc     = id_pc_q;

  assign id_opcode = id_instr_q[31:26];
  assign id_functR = id_instr_q[6:0];
  assign id_rs     = id_instr_q[25:21];
  assign id_rt     = id_instr_q[20:16];
  assign id_rd     = id_instr_q[15:11];
  assign id_imm    = id_instr_q[15:0];

endmodule

// File: tb/tb_fetch_stage.sv
// Self-checking bench for fetch_stage: queue-based fetch model compared every cycle,
// plus literal expectations for reset, decode slicing, skid order, redirects and wrap.
module tb_fetch_stage;

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc;
  } entry_t;

  logic        clk;
  logic        rst;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic        id_stall;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        id_valid;
  logic [31:0] id_instr;
  logic [31:0] id_pc;
  logic [5:0]  id_opcode;
  logic [6:0]  id_functR;
  logic [4:0]  id_rs, id_rt, id_rd;
  logic [15:0] id_imm;

  // Second instance with a non-zero reset PC and memory acking every request at once.
  logic        b_rst;
  logic        b_req;
  logic [31:0] b_addr;
  logic        b_valid;
  logic [31:0] b_instr;
  logic [31:0] b_pc;
  logic [5:0]  b_opcode;
  logic [6:0]  b_functR;
  logic [4:0]  b_rs, b_rt, b_rd;
  logic [15:0] b_imm;

  fetch_stage #(.ADDR_W(32), .RESET_PC(32'h0)) dut (
    .clk(clk), .rst(rst),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack), .imem_rdata(imem_rdata),
    .id_stall(id_stall), .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .id_valid(id_valid), .id_instr(id_instr), .id_pc(id_pc),
    .id_opcode(id_opcode), .id_functR(id_functR),
    .id_rs(id_rs), .id_rt(id_rt), .id_rd(id_rd), .id_imm(id_imm)
  );

  fetch_stage #(.ADDR_W(32), .RESET_PC(32'h40)) dut_b (
    .clk(clk), .rst(b_rst),
    .imem_req(b_req), .imem_addr(b_addr), .imem_ack(b_req), .imem_rdata(32'h1234_5678),
    .id_stall(1'b0), .redirect_valid(1'b0), .redirect_pc(32'h0),
    .id_valid(b_valid), .id_instr(b_instr), .id_pc(b_pc),
    .id_opcode(b_opcode), .id_functR(b_functR),
    .id_rs(b_rs), .id_rt(b_rt), .id_rd(b_rd), .id_imm(b_imm)
  );

  always #5 clk = ~clk;

  int n_cmp;
  int n_err;
  int mem_lat;
  int mem_wait;
  logic [31:0] accepted[$];

  // Model state: words waiting to be taken by decode (front = IF/ID register), plus the
  // single outstanding request and whether its data is to be discarded.
  entry_t      outq[$];
  logic        m_started;
  logic        m_req;
  logic        m_discard;
  logic [31:0] m_req_addr;
  logic [31:0] m_next_pc;

  function automatic logic [31:0] word(input logic [31:0] a);
    if (a == 32'h10) return 32'h00A4_1020;
    return {16'hC0DE ^ a[31:16], a[15:0]};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic model_reset();
    outq.delete();
    m_started  = 1'b0;
    m_req      = 1'b0;
    m_discard  = 1'b0;
    m_next_pc  = 32'h0;
    m_req_addr = 32'h0;
  endtask

  task automatic model_edge(input logic ack, input logic [31:0] rdata, input logic stall,
                            input logic redir, input logic [31:0] rpc);
    logic   acked;
    entry_t e;
    acked = m_req && ack;
    if (!m_started) begin
      m_started = 1'b1;
      if (redir) m_next_pc = {rpc[31:2], 2'b00};
      m_req      = 1'b1;
      m_req_addr = m_next_pc;
      return;
    end
    if (redir) begin
      outq.delete();
      m_next_pc = {rpc[31:2], 2'b00};
      if (m_req && !acked) begin
        m_discard = 1'b1;
      end else begin
        m_discard  = 1'b0;
        m_req      = 1'b1;
        m_req_addr = m_next_pc;
      end
      return;
    end
    if (outq.size() != 0 && !stall) void'(outq.pop_front());
    if (acked) begin
      if (m_discard) begin
        m_discard = 1'b0;
      end else begin
        e.instr = rdata;
        e.pc    = m_req_addr;
        outq.push_back(e);
        m_next_pc = m_next_pc + 32'd4;
      end
      m_req = 1'b0;
    end
    if (!m_req && outq.size() <= 1) begin
      m_req      = 1'b1;
      m_req_addr = m_next_pc;
    end
  endtask

  task automatic compare_outputs();
    entry_t e;
    check("imem_req", {31'b0, imem_req}, {31'b0, m_req});
    if (m_req) check("imem_addr", imem_addr, m_req_addr);
    check("id_valid", {31'b0, id_valid}, {31'b0, outq.size() != 0});
    if (outq.size() != 0) begin
      e = outq[0];
      check("id_instr", id_instr, e.instr);
      check("id_pc", id_pc, e.pc);
      check("id_opcode", {26'b0, id_opcode}, {26'b0, e.instr[31:26]});
      check("id_functR", {25'b0, id_functR}, {25'b0, e.instr[6:0]});
      check("id_rs", {27'b0, id_rs}, {27'b0, e.instr[25:21]});
      check("id_rt", {27'b0, id_rt}, {27'b0, e.instr[20:16]});
      check("id_rd", {27'b0, id_rd}, {27'b0, e.instr[15:11]});
      check("id_imm", {16'b0, id_imm}, {16'b0, e.instr[15:0]});
    end
  endtask

  // One clock: entered and left at a falling edge with DUT outputs settled.
  task automatic step();
    logic        req_s, ack_s, stall_s, redir_s;
    logic [31:0] rdata_s, rpc_s;
    compare_outputs();
    if (imem_req && mem_wait == mem_lat - 1) begin
      imem_ack   = 1'b1;
      imem_rdata = word(imem_addr);
    end else begin
      imem_ack   = 1'b0;
      imem_rdata = 32'hDEAD_BEEF;
    end
    if (id_valid && !id_stall && !redirect_valid) accepted.push_back(id_pc);
    req_s = imem_req; ack_s = imem_ack; rdata_s = imem_rdata;
    stall_s = id_stall; redir_s = redirect_valid; rpc_s = redirect_pc;
    @(posedge clk);
    if (rst) begin
      model_reset();
      mem_wait = 0;
    end else begin
      model_edge(ack_s, rdata_s, stall_s, redir_s, rpc_s);
      if (req_s && ack_s) mem_wait = 0;
      else if (req_s) mem_wait++;
    end
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    imem_ack = 1'b0;
    imem_rdata = 32'h0;
    id_stall = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc = 32'h0;
    mem_wait = 0;
    model_reset();
    @(negedge clk);
    @(negedge clk);
    check("rst_imem_req", {31'b0, imem_req}, 32'h0);
    check("rst_imem_addr", imem_addr, 32'h0);
    check("rst_id_valid", {31'b0, id_valid}, 32'h0);
    check("rst_id_instr", id_instr, 32'h0);
    check("rst_id_pc", id_pc, 32'h0);
    check("rst_opcode_functR", {19'b0, id_opcode, id_functR}, 32'h0);
    rst = 1'b0;
  endtask

  initial begin
    int budget;
    bit [23:0] pat;
    clk = 1'b0;
    rst = 1'b1;
    b_rst = 1'b1;
    n_cmp = 0;
    n_err = 0;
    mem_lat = 1;
    mem_wait = 0;
    imem_ack = 1'b0;
    imem_rdata = 32'h0;
    id_stall = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc = 32'h0;
    model_reset();

    // RESET_PC=0x40 instance: first fetch address, and a reset landing mid-request.
    @(negedge clk);
    check("b_rst_addr", b_addr, 32'h40);
    check("b_rst_valid", {31'b0, b_valid}, 32'h0);
    b_rst = 1'b0;
    @(negedge clk);
    check("b_first_req", {31'b0, b_req}, 32'h1);
    check("b_first_addr", b_addr, 32'h40);
    @(negedge clk);
    check("b_id_pc", b_pc, 32'h40);
    check("b_id_instr", b_instr, 32'h1234_5678);
    check("b_next_addr", b_addr, 32'h44);
    #2 b_rst = 1'b1;
    #1;
    check("b_midreset_req", {31'b0, b_req}, 32'h0);
    check("b_midreset_valid", {31'b0, b_valid}, 32'h0);
    check("b_midreset_addr", b_addr, 32'h40);
    @(negedge clk);
    b_rst = 1'b0;
    @(negedge clk);
    check("b_rereq", {31'b0, b_req}, 32'h1);
    check("b_rereq_addr", b_addr, 32'h40);

    // Streaming with ack tied to req, a 5-cycle stall, then decode of 0x00A41020.
    do_reset();
    mem_lat = 1;
    accepted.delete();
    repeat (2) step();
    check("stream_id_pc", id_pc, 32'h0);
    check("stream_addr", imem_addr, 32'h4);
    id_stall = 1'b1;
    repeat (5) step();
    check("hold_no_req", {31'b0, imem_req}, 32'h0);
    check("hold_id_pc", id_pc, 32'h0);
    id_stall = 1'b0;
    repeat (4) step();
    check("accepted_count", {31'b0, accepted.size() >= 4}, 32'h1);
    if (accepted.size() >= 4) begin
      for (int i = 0; i < 4; i++) check("accepted_order", accepted[i], 32'(i * 4));
    end
    budget = 40;
    while (!(outq.size() != 0 && outq[0].pc == 32'h10) && budget > 0) begin
      step();
      budget--;
    end
    if (budget == 0) begin
      n_cmp++;
      n_err++;
      $display("FAIL wait_pc10: got timeout expected id_pc 0x00000010");
    end
    check("dec_pc", id_pc, 32'h10);
    check("dec_opcode", {26'b0, id_opcode}, 32'h00);
    check("dec_rs", {27'b0, id_rs}, 32'd5);
    check("dec_rt", {27'b0, id_rt}, 32'd4);
    check("dec_rd", {27'b0, id_rd}, 32'd2);
    check("dec_functR", {25'b0, id_functR}, 32'h20);
    check("dec_imm", {16'b0, id_imm}, 32'h1020);
    repeat (3) step();

    // 3-cycle memory, redirect to 0x103 one cycle into the request.
    do_reset();
    mem_lat = 3;
    step();
    step();
    redirect_valid = 1'b1;
    redirect_pc = 32'h103;
    step();
    redirect_valid = 1'b0;
    check("drop_req", {31'b0, imem_req}, 32'h1);
    check("drop_addr_held", imem_addr, 32'h0);
    check("drop_valid", {31'b0, id_valid}, 32'h0);
    step();
    check("drop_new_addr", imem_addr, 32'h100);
    check("drop_valid_after", {31'b0, id_valid}, 32'h0);
    repeat (3) step();
    check("drop_first_valid", {31'b0, id_valid}, 32'h1);
    check("drop_first_pc", id_pc, 32'h100);
    repeat (3) step();

    // Redirect together with ack while stalled, then a redirect out of HOLD.
    do_reset();
    mem_lat = 1;
    repeat (2) step();
    id_stall = 1'b1;
    redirect_valid = 1'b1;
    redirect_pc = 32'h200;
    step();
    redirect_valid = 1'b0;
    check("rda_valid", {31'b0, id_valid}, 32'h0);
    check("rda_req", {31'b0, imem_req}, 32'h1);
    check("rda_addr", imem_addr, 32'h200);
    step();
    check("rda_load_pc", id_pc, 32'h200);
    step();
    check("rda_hold", {31'b0, imem_req}, 32'h0);
    redirect_valid = 1'b1;
    redirect_pc = 32'h300;
    step();
    redirect_valid = 1'b0;
    check("hold_redir_valid", {31'b0, id_valid}, 32'h0);
    check("hold_redir_addr", imem_addr, 32'h300);
    id_stall = 1'b0;
    repeat (3) step();

    // PC wrap-around.
    do_reset();
    mem_lat = 1;
    step();
    redirect_valid = 1'b1;
    redirect_pc = 32'hFFFF_FFFC;
    step();
    redirect_valid = 1'b0;
    check("wrap_addr_top", imem_addr, 32'hFFFF_FFFC);
    step();
    check("wrap_addr", imem_addr, 32'h0);
    check("wrap_id_pc", id_pc, 32'hFFFF_FFFC);
    step();

    // 2-cycle memory with an irregular stall pattern and one redirect.
    do_reset();
    mem_lat = 2;
    pat = 24'b0110_0011_1001_1100_0101_1110;
    for (int i = 0; i < 24; i++) begin
      id_stall = pat[i];
      redirect_valid = (i == 13);
      redirect_pc = 32'h82;
      step();
    end
    id_stall = 1'b0;
    redirect_valid = 1'b0;
    repeat (6) step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
